pipe_hazard_ctrl: RTL

//  Central stall/bubble sequencer for the 5-stage pipeline (F/D/E/M/W). Drives the stall and bubble inputs of

---
 rtl/pipe_hazard_ctrl_pkg.sv | 14 +
 rtl/pipe_hazard_ctrl_hazard_detect.sv | 17 +
 rtl/pipe_hazard_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_pkg: shared types and defaults for the pipeline hazard controller
package pipe_pkg;
  localparam int REG_W = 5;
  localparam int XLEN_DEF = 64;
`ifdef PIPE_PERF_CNT_EN
  localparam int PERF_W_DEF = 32;
`endif
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    PEND     = 2'd3
  } state_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: load-use compare between the load in E and the sources of the instr in D
module hazard_detect
  import pipe_pkg::*;
(
  input  logic [REG_W-1:0] i_rs1,
  input  logic [REG_W-1:0] i_rs2,
  input  logic             i_use_rs1,
  input  logic             i_use_rs2,
  input  logic [REG_W-1:0] i_rd,
  input  logic             i_memrd,
  output logic             o_hit
);
  logic w_rd_nz;
  assign w_rd_nz = |i_rd;
  // x0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb o_hit = i_memrd && w_rd_nz && ((i_use_rs1 && i_rs1 == i_rd) || (i_use_rs2 && i_rs2 == i_rd));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble sequencer for the F/D/E/M/W pipeline; optional PIPE_PERF_CNT_EN adds perf counters
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
`ifdef PIPE_PERF_CNT_EN
  , parameter int PERF_W = PERF_W_DEF
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fetch_i_busy,
  input  logic [REG_W-1:0] dec_i_rs1,
  input  logic [REG_W-1:0] dec_i_rs2,
  input  logic             dec_i_use_rs1,
  input  logic             dec_i_use_rs2,
  input  logic [REG_W-1:0] exe_i_rd,
  input  logic             exe_i_memrd,
  input  logic             exe_i_redirect,
  input  logic [XLEN-1:0]  exe_i_redirect_pc,
  input  logic             exe_i_div_busy,
  input  logic             mem_i_busy,
  output logic             ctrl_o_redirect,
  output logic [XLEN-1:0]  ctrl_o_redirect_pc,
  output logic             regF_stall,
  output logic             regD_stall,
  output logic             regD_bubble,
  output logic             regE_stall,
  output logic             regE_bubble,
  output logic             regM_stall,
  output logic             regM_bubble,
  output logic             regW_bubble,
  output logic [1:0]       ctrl_o_state
`ifdef PIPE_PERF_CNT_EN
  ,
  output logic [PERF_W-1:0] perf_o_stall_cyc,
  output logic [PERF_W-1:0] perf_o_flush_cnt,
  output logic [PERF_W-1:0] perf_o_lu_cnt
`endif
);
  state_e            r_state;
  state_e            w_next;
  logic              r_pend_v;
  logic [XLEN-1:0]   r_pend_pc;
  logic              w_lu;
  logic              w_mem;
  logic              w_div;
  logic              w_blk;
  logic              w_redir;
  logic              w_lu_act;
  logic              w_fb_act;

  hazard_detect u_hd (
    .i_rs1     (dec_i_rs1),
    .i_rs2     (dec_i_rs2),
    .i_use_rs1 (dec_i_use_rs1),
    .i_use_rs2 (dec_i_use_rs2),
    .i_rd      (exe_i_rd),
    .i_memrd   (exe_i_memrd),
    .o_hit     (w_lu)
  );

  // priority ladder: mem wait > div wait > redirect > load-use > fetch miss
  always_comb begin
    w_mem    = mem_i_busy;
    w_div    = exe_i_div_busy && !mem_i_busy;
    w_blk    = w_mem || w_div;
    w_redir  = !w_blk && (exe_i_redirect || (r_state == PEND && r_pend_v));
    w_lu_act = !w_blk && !w_redir && w_lu;
    w_fb_act = !w_blk && !w_redir && !w_lu && fetch_i_busy;
  end

  // stall/bubble and redirect outputs; reset forces every downstream register to a bubble
  always_comb begin
    regF_stall         = rst && (w_blk || w_lu_act || w_fb_act);
    regD_stall         = rst && (w_blk || w_lu_act);
    regD_bubble        = !rst || w_redir || w_fb_act;
    regE_stall         = rst && w_blk;
    regE_bubble        = !rst || w_redir || w_lu_act;
    regM_stall         = rst && w_mem;
    regM_bubble        = !rst || w_div;
    regW_bubble        = !rst || w_mem;
    ctrl_o_redirect    = rst && w_redir;
    ctrl_o_redirect_pc = !(rst && w_redir) ? '0 : exe_i_redirect ? exe_i_redirect_pc : r_pend_pc;
    ctrl_o_state       = r_state;
  end

  // next state: waits track the blocking unit; a held redirect detours through PEND before RUN
  always_comb begin
    w_next = r_state;
    case (r_state)
      PEND:    w_next = w_blk ? PEND : RUN;
      default: w_next = w_mem ? MEM_WAIT : w_div ? DIV_WAIT : (r_pend_v && !exe_i_redirect) ? PEND : RUN;
    endcase
  end

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= RUN;
    else      r_state <= w_next;
  end

  // redirect raised while frozen is held here; the newest one wins, and any emitted redirect retires it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_v  <= 1'b0;
      r_pend_pc <= '0;
    end else if (w_blk && exe_i_redirect) begin
      r_pend_v  <= 1'b1;
      r_pend_pc <= exe_i_redirect_pc;
    end else if (w_redir) begin
      r_pend_v  <= 1'b0;
    end
  end

`ifdef PIPE_PERF_CNT_EN
  logic [PERF_W-1:0] r_stall_cyc;
  logic [PERF_W-1:0] r_flush_cnt;
  logic [PERF_W-1:0] r_lu_cnt;

  // saturating event counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cyc <= '0;
      r_flush_cnt <= '0;
      r_lu_cnt    <= '0;
    end else begin
      if (regF_stall && !(&r_stall_cyc))  r_stall_cyc <= r_stall_cyc + PERF_W'(1);
      if (w_redir && !(&r_flush_cnt))     r_flush_cnt <= r_flush_cnt + PERF_W'(1);
      if (w_lu_act && !(&r_lu_cnt))       r_lu_cnt    <= r_lu_cnt + PERF_W'(1);
    end
  end

  assign perf_o_stall_cyc = r_stall_cyc;
  assign perf_o_flush_cnt = r_flush_cnt;
  assign perf_o_lu_cnt    = r_lu_cnt;
`endif
endmodule
